des_result_reader: RTL and testbench

Result-side reader for the DES core. It captures each finished Encrypt/Decrypt pair from the core into a 64-entry result store, tagged by the same 6-bit block address the host used when loading key and message. It then serves host reads by address over a valid/ready handshake. A read to an address whose result is not yet present waits for it, up to a bounded timeout. The block sits between the DES core outputs and the host readout path; it is the read counterpart of the key/message write ports.

---
 rtl/des_result_reader.sv | 182 ++++++++++++++++++
 tb/tb_des_result_reader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_result_reader.sv
// Result-side reader for the DES core: captures Encrypt/Decrypt pairs by block address
// and serves host reads over valid/ready with a bounded wait. Option: DES_RD_CLEAR_ON_READ_EN.
module des_result_reader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [1:64]       enc_in,
  input  logic [1:64]       dec_in,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_sel,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [1:64]       rd_data,
  output logic              rd_err,
  output logic              rd_busy,
  output logic [ADDR_W:0]   done_cnt,
  output logic              ovf
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              sel_reg;
  logic [CNT_W-1:0]  wait_cnt_reg;
  logic [CNT_W-1:0]  wait_cnt_next;

  logic [1:64]       enc_mem [DEPTH];
  logic [1:64]       dec_mem [DEPTH];
  logic [DEPTH-1:0]  done_reg;

  logic              wr_was_done;
  logic              wr_hits_lat;
  logic              wr_hits_req;
  logic              rd_clear;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [1:64]       mem_word;
  logic [1:64]       in_word_req;
  logic [1:64]       in_word_lat;

  // Data store carries no reset; validity lives entirely in done_reg.
  always_ff @(posedge clk) begin
    if (res_valid) begin
      enc_mem[res_addr] <= enc_in;
      dec_mem[res_addr] <= dec_in;
    end
  end

  assign wr_was_done = done_reg[res_addr];
  assign wr_hits_lat = res_valid && (res_addr == addr_reg);
  assign wr_hits_req = res_valid && (res_addr == rd_addr);

`ifdef DES_RD_CLEAR_ON_READ_EN
  assign rd_clear = (state_reg == RESP) && rd_valid && rd_ready && !rd_err;
`else
  assign rd_clear = 1'b0;
`endif

  // A same-address write in the consuming cycle keeps the entry alive.
  assign cnt_inc = res_valid && !wr_was_done;
  assign cnt_dec = rd_clear && !wr_hits_lat && done_reg[addr_reg];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_done
      logic done_bit_reg;
      logic wr_set;
      logic rd_clr;

      assign wr_set = res_valid && (res_addr == ADDR_W'(gi));
      assign rd_clr = rd_clear && (addr_reg == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          done_bit_reg <= 1'b0;
        end else if (wr_set) begin
          done_bit_reg <= 1'b1;
        end else if (rd_clr) begin
          done_bit_reg <= 1'b0;
        end
      end

      assign done_reg[gi] = done_bit_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (res_valid && wr_was_done) begin
        ovf <= 1'b1;
      end
      if (cnt_inc && !cnt_dec) begin
        done_cnt <= done_cnt + 1'b1;
      end else if (!cnt_inc && cnt_dec) begin
        done_cnt <= done_cnt - 1'b1;
      end
    end
  end

  assign mem_word      = rd_sel  ? dec_mem[rd_addr] : enc_mem[rd_addr];
  assign in_word_req   = rd_sel  ? dec_in : enc_in;
  assign in_word_lat   = sel_reg ? dec_in : enc_in;
  assign wait_cnt_next = wait_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      sel_reg      <= 1'b0;
      wait_cnt_reg <= '0;
      rd_valid     <= 1'b0;
      rd_err       <= 1'b0;
      rd_busy      <= 1'b0;
      rd_data      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rd_req) begin
            addr_reg <= rd_addr;
            sel_reg  <= rd_sel;
            rd_busy  <= 1'b1;
            if (wr_hits_req) begin
              rd_data   <= in_word_req;
              rd_valid  <= 1'b1;
              rd_err    <= 1'b0;
              state_reg <= RESP;
            end else if (done_reg[rd_addr]) begin
              rd_data   <= mem_word;
              rd_valid  <= 1'b1;
              rd_err    <= 1'b0;
              state_reg <= RESP;
            end else begin
              wait_cnt_reg <= '0;
              state_reg    <= WAIT;
            end
          end
        end
        WAIT: begin
          // An arriving result beats the timeout on the same edge.
          if (wr_hits_lat) begin
            rd_data   <= in_word_lat;
            rd_valid  <= 1'b1;
            rd_err    <= 1'b0;
            state_reg <= RESP;
          end else if (wait_cnt_next == TIMEOUT_C) begin
            rd_data   <= '0;
            rd_valid  <= 1'b1;
            rd_err    <= 1'b1;
            state_reg <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_next;
          end
        end
        RESP: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            rd_busy   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          rd_valid  <= 1'b0;
          rd_err    <= 1'b0;
          rd_busy   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_des_result_reader.sv
// Self-checking bench for des_result_reader: directed scenarios plus randomized reads
// against an array/counter model of the result store.
module tb_des_result_reader;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [1:64]       enc_in;
  logic [1:64]       dec_in;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_sel;
  logic              rd_ready;
  logic              rd_valid;
  logic [1:64]       rd_data;
  logic              rd_err;
  logic              rd_busy;
  logic [ADDR_W:0]   done_cnt;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  logic [63:0]       enc_m [DEPTH];
  logic [63:0]       dec_m [DEPTH];
  bit                done_m [DEPTH];
  logic [ADDR_W:0]   cnt_m;
  bit                ovf_m;
  logic [ADDR_W-1:0] cur_addr;

  des_result_reader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_addr(res_addr), .enc_in(enc_in), .dec_in(dec_in),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_busy(rd_busy),
    .done_cnt(done_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    res_valid = 1'b0; res_addr = '0; enc_in = '0; dec_in = '0;
    rd_req = 1'b0; rd_addr = '0; rd_sel = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) done_m[i] = 1'b0;
    cnt_m = '0;
    ovf_m = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock edge; the model applies what the spec says happens on that edge,
  // then the write-side outputs are checked.
  task automatic tick();
    bit                hs;
    bit                w;
    logic [ADDR_W-1:0] a;
    logic [63:0]       e;
    logic [63:0]       d;
    hs = rd_valid && rd_ready && !rd_err;
    w = res_valid; a = res_addr; e = enc_in; d = dec_in;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (w) begin
        if (done_m[a]) ovf_m = 1'b1;
        else cnt_m = cnt_m + 7'd1;
        done_m[a] = 1'b1;
        enc_m[a] = e;
        dec_m[a] = d;
      end
`ifdef DES_RD_CLEAR_ON_READ_EN
      if (hs && !(w && a == cur_addr) && done_m[cur_addr]) begin
        done_m[cur_addr] = 1'b0;
        cnt_m = cnt_m - 7'd1;
      end
`else
      if (hs) cnt_m = cnt_m;
`endif
      checks++;
      if (done_cnt !== cnt_m || ovf !== ovf_m) begin
        errors++;
        $display("FAIL write_side: done_cnt=%0d ovf=%0b expected done_cnt=%0d ovf=%0b",
                 done_cnt, ovf, cnt_m, ovf_m);
      end
    end
  endtask

  task automatic write_now(input logic [ADDR_W-1:0] a, input logic [63:0] e, input logic [63:0] d);
    res_valid = 1'b1; res_addr = a; enc_in = e; dec_in = d;
  endtask

  task automatic no_write();
    res_valid = 1'b0;
  endtask

  task automatic check_resp(input string name, input logic [63:0] exp_data, input bit exp_err);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_data || rd_err !== exp_err || rd_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s: valid=%0b data=%h err=%0b busy=%0b expected valid=1 data=%h err=%0b busy=1",
               name, rd_valid, rd_data, rd_err, rd_busy, exp_data, exp_err);
    end else begin
      $display("resp %s: addr=%0d data=%h err=%0b", name, cur_addr, rd_data, rd_err);
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (rd_valid !== 1'b0 || rd_busy !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%0b busy=%0b err=%0b expected all 0", name, rd_valid, rd_busy, rd_err);
    end
  endtask

  task automatic check_waiting(input string name);
    checks++;
    if (rd_valid !== 1'b0 || rd_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s: valid=%0b busy=%0b expected valid=0 busy=1", name, rd_valid, rd_busy);
    end
  endtask

  task automatic request(input logic [ADDR_W-1:0] a, input bit sel);
    rd_req = 1'b1; rd_addr = a; rd_sel = sel; cur_addr = a;
  endtask

  task automatic accept(input string name);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_idle(name);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_busy !== 1'b0 || ovf !== 1'b0 ||
        rd_data !== 64'd0 || done_cnt !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b err=%0b busy=%0b ovf=%0b data=%h cnt=%0d expected all 0",
               rd_valid, rd_err, rd_busy, ovf, rd_data, done_cnt);
    end
  endtask

  task automatic test_hit();
    do_reset();
    write_now(6'd0, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210);
    tick();
    no_write();
    request(6'd0, 1'b1);
    rd_ready = 1'b1;
    tick();
    rd_req = 1'b0;
    check_resp("hit_addr0", 64'hFEDCBA9876543210, 1'b0);
    checks++;
    if (done_cnt !== 7'd1) begin
      errors++;
      $display("FAIL hit_done_cnt: got %0d expected 1", done_cnt);
    end
    tick();
    rd_ready = 1'b0;
    check_idle("hit_accept");
  endtask

  task automatic test_miss();
    do_reset();
    request(6'd29, 1'b0);
    tick();
    rd_req = 1'b0;
    repeat (10) tick();
    check_waiting("miss_wait");
    write_now(6'd29, 64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A);
    tick();
    no_write();
    check_resp("miss_addr29", 64'hA5A5A5A5A5A5A5A5, 1'b0);
    accept("miss_accept");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    request(6'd5, 1'b0);
    tick();
    rd_req = 1'b0;
    n = 0;
    while (rd_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles after request edge expected %0d", n, TIMEOUT);
    end
    check_resp("timeout_resp", 64'd0, 1'b1);
    repeat (3) tick();
    check_resp("timeout_hold", 64'd0, 1'b1);
    accept("timeout_accept");
  endtask

  task automatic test_ovf();
    do_reset();
    write_now(6'd3, 64'h1111, 64'h2222);
    tick();
    write_now(6'd3, 64'h3333, 64'h4444);
    tick();
    no_write();
    checks++;
    if (ovf !== 1'b1 || done_cnt !== 7'd1) begin
      errors++;
      $display("FAIL ovf_double_write: ovf=%0b cnt=%0d expected ovf=1 cnt=1", ovf, done_cnt);
    end
    request(6'd3, 1'b0);
    tick();
    rd_req = 1'b0;
    check_resp("ovf_read1", 64'h3333, 1'b0);
    accept("ovf_accept1");
    request(6'd3, 1'b1);
    tick();
    rd_req = 1'b0;
`ifdef DES_RD_CLEAR_ON_READ_EN
    check_waiting("consumed_wait");
    tick();
    check_waiting("consumed_wait2");
    write_now(6'd3, 64'h5555, 64'h6666);
    tick();
    no_write();
    check_resp("consumed_refill", 64'h6666, 1'b0);
`else
    check_resp("ovf_read2", 64'h4444, 1'b0);
`endif
    accept("ovf_accept2");
  endtask

  task automatic test_bypass();
    logic [63:0] e;
    logic [63:0] d;
    logic [63:0] exp;
    bit          sel;
    do_reset();
    e = {$urandom, $urandom};
    d = {$urandom, $urandom};
    sel = 1'($urandom_range(0, 1));
    exp = sel ? d : e;
    write_now(6'd4, e, d);
    request(6'd4, sel);
    tick();
    rd_req = 1'b0;
    check_resp("bypass_addr4", exp, 1'b0);
    for (int i = 0; i < 5; i++) begin
      write_now(6'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, {$urandom, $urandom});
      tick();
      no_write();
      check_resp("bypass_hold", exp, 1'b0);
    end
    accept("bypass_accept");
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      write_now(6'(10 + i), {$urandom, $urandom}, {$urandom, $urandom});
      tick();
    end
    no_write();
    rd_ready = 1'b1;
    request(6'd10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = 6'(10 + i);
      tick();
      check_resp("b2b_resp", enc_m[a], 1'b0);
      // Next address is presented while in RESP and must be ignored until IDLE.
      if (i < 3) request(6'(11 + i), 1'b0);
      else rd_req = 1'b0;
      tick();
      check_idle("b2b_gap");
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] o;
    logic [63:0]       exp;
    bit                sel;
    int                waits;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      write_now(6'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, {$urandom, $urandom});
      tick();
    end
    no_write();
    for (int t = 0; t < 40; t++) begin
      a = 6'($urandom_range(0, DEPTH - 1));
      o = a + 6'($urandom_range(1, DEPTH - 1));
      sel = 1'($urandom_range(0, 1));
      request(a, sel);
      if ($urandom_range(0, 1) == 1) write_now(o, {$urandom, $urandom}, {$urandom, $urandom});
      if (done_m[a]) begin
        exp = sel ? dec_m[a] : enc_m[a];
        tick();
        rd_req = 1'b0;
        no_write();
        check_resp("rand_hit", exp, 1'b0);
      end else begin
        tick();
        rd_req = 1'b0;
        no_write();
        waits = $urandom_range(0, 5);
        for (int k = 0; k < waits; k++) begin
          if ($urandom_range(0, 1) == 1) write_now(a + 6'($urandom_range(1, DEPTH - 1)),
                                                   {$urandom, $urandom}, {$urandom, $urandom});
          tick();
          no_write();
        end
        check_waiting("rand_miss_wait");
        write_now(a, {$urandom, $urandom}, {$urandom, $urandom});
        exp = sel ? 64'(dec_in) : 64'(enc_in);
        tick();
        no_write();
        check_resp("rand_miss", exp, 1'b0);
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        check_resp("rand_hold", exp, 1'b0);
      end
      accept("rand_accept");
    end
  endtask

  task automatic check_async_zero(input string name);
    checks++;
    if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_busy !== 1'b0 || ovf !== 1'b0 ||
        rd_data !== 64'd0 || done_cnt !== 7'd0) begin
      errors++;
      $display("FAIL %s: valid=%0b err=%0b busy=%0b ovf=%0b data=%h cnt=%0d expected all 0",
               name, rd_valid, rd_err, rd_busy, ovf, rd_data, done_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_now(6'd7, 64'hDEAD, 64'hBEEF);
    tick();
    write_now(6'd7, 64'hCAFE, 64'hF00D);
    tick();
    no_write();
    request(6'd8, 1'b0);
    tick();
    rd_req = 1'b0;
    check_waiting("pre_reset_wait");
    #2 rst_n = 1'b0;
    #1 check_async_zero("reset_in_wait");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    write_now(6'd9, 64'h1234, 64'h5678);
    request(6'd9, 1'b1);
    tick();
    rd_req = 1'b0;
    no_write();
    check_resp("pre_reset_resp", 64'h5678, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_async_zero("reset_in_resp");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    request(6'd7, 1'b0);
    tick();
    rd_req = 1'b0;
    check_waiting("done_cleared_by_reset");
    do_reset();
  endtask

  initial begin
    idle_inputs();
    cur_addr = '0;
    model_reset();
    test_reset();
    test_hit();
    test_miss();
    test_timeout();
    test_ovf();
    test_bypass();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
